// File: rtl/axis_burst_reader.sv
// axis_burst_reader: drains an AXI-stream FIFO in fixed-length bursts framed
// by m_axis_tlast_o. If the residue stays below the FIFO threshold, it is
// flushed as a short frame once a timeout expires.
// Datapath: slave port -> one-beat hold register (h) -> registered output (o).
module axis_burst_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ena_i,
    input  logic                  fifo_empty_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tlast_o,
    output logic                  busy_o,
    output logic                  flushing_o
);

    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned TmoW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);
    localparam logic [TmoW-1:0]  TmoLimit = TmoW'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StFlush = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [TmoW-1:0]         tmo_q, tmo_d;

    logic                    h_valid_q, h_valid_d;
    logic [DATA_WIDTH-1:0]   h_data_q, h_data_d;
    logic                    h_last_q, h_last_d;

    logic                    o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
    logic                    o_last_q, o_last_d;

    logic                    busy_q;
    logic                    flushing_q;

    logic                    o_load;
    logic                    h_move;
    logic                    s_ready;
    logic                    accept;
    logic                    beat_last;
    logic                    pend_flush;
    logic                    flush_term;

    // Handshake and framing decisions shared by the datapath and the FSM.
    always_comb begin
        o_load     = ~o_valid_q | m_axis_tready_i;
        h_move     = h_valid_q & o_load;
        s_ready    = ena_i & (state_q != StIdle) & (~h_valid_q | o_load);
        accept     = s_ready & s_axis_tvalid_i;
        beat_last  = (beat_q == LastBeat);
        // A flush beat waits in h until we know whether another beat follows.
        // A leftover burst beat already carries tlast and never waits.
        pend_flush = (state_q == StFlush) & h_valid_q & ~h_last_q;
        // Source went quiet with a flush beat held: it closes the frame.
        flush_term = pend_flush & o_load & ~s_axis_tvalid_i;
    end

    // Hold and output register next-state.
    always_comb begin
        h_valid_d = h_valid_q;
        h_data_d  = h_data_q;
        h_last_d  = h_last_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_last_d  = o_last_q;

        if (o_load) begin
            o_valid_d = h_valid_q;
            if (h_valid_q) begin
                o_data_d = h_data_q;
                o_last_d = h_last_q | flush_term;
            end else begin
                o_last_d = 1'b0;
            end
        end

        if (h_move) begin
            h_valid_d = 1'b0;
        end
        if (accept) begin
            h_valid_d = 1'b1;
            h_data_d  = s_axis_tdata_i;
            h_last_d  = beat_last;
        end
    end

    // Frame FSM: beat counter, timeout counter and state transitions.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tmo_d   = '0;

        unique case (state_q)
            StIdle: begin
                beat_d = '0;
                if (!fifo_empty_i) begin
                    state_d = StBurst;
                end else if ((TIMEOUT != 0) && s_axis_tvalid_i) begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TmoLimit) begin
                        state_d = StFlush;
                        tmo_d   = '0;
                    end
                end
            end

            StBurst: begin
                // fifo_empty_i is deliberately ignored: the frame is committed.
                if (accept) begin
                    if (beat_last) begin
                        state_d = StIdle;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            StFlush: begin
                if (accept) begin
                    if (beat_last) begin
                        state_d = StIdle;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (flush_term) begin
                    state_d = StIdle;
                    beat_d  = '0;
                end else if (!s_axis_tvalid_i && (beat_q == '0)) begin
                    // Nothing of this flush was taken: leave without a frame.
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                beat_d  = '0;
            end
        endcase
    end

    // State registers; ena_i low freezes everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            tmo_q      <= '0;
            h_valid_q  <= 1'b0;
            h_data_q   <= '0;
            h_last_q   <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            flushing_q <= 1'b0;
        end else if (ena_i) begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            tmo_q      <= tmo_d;
            h_valid_q  <= h_valid_d;
            h_data_q   <= h_data_d;
            h_last_q   <= h_last_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_last_q   <= o_last_d;
            busy_q     <= (state_d != StIdle);
            flushing_q <= (state_d == StFlush);
        end
    end

    assign s_axis_tready_o = s_ready;
    assign m_axis_tvalid_o = o_valid_q;
    assign m_axis_tdata_o  = o_data_q;
    assign m_axis_tlast_o  = o_last_q;
    assign busy_o          = busy_q;
    assign flushing_o      = flushing_q;

endmodule

// File: tb/tb_axis_burst_reader.sv
// Directed bench for axis_burst_reader with BURST_LEN=4, TIMEOUT=8.
// Inputs change on the falling edge and outputs are sampled 1 time unit later.
module tb_axis_burst_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned BL = 4;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          fifo_empty;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          busy;
    logic          flushing;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] out_d[$];
    logic          out_l[$];

    always #5 clk = ~clk;

    axis_burst_reader #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ena_i          (ena),
        .fifo_empty_i   (fifo_empty),
        .s_axis_tvalid_i(s_tvalid),
        .s_axis_tready_o(s_tready),
        .s_axis_tdata_i (s_tdata),
        .m_axis_tvalid_o(m_tvalid),
        .m_axis_tready_i(m_tready),
        .m_axis_tdata_o (m_tdata),
        .m_axis_tlast_o (m_tlast),
        .busy_o         (busy),
        .flushing_o     (flushing)
    );

    // One clock cycle: present the source head, log both handshakes.
    task automatic tick();
        s_tvalid = (src_q.size() > 0);
        s_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
        #1;
        if (s_tvalid && s_tready) begin
            src_q.delete(0);
            n_acc++;
        end
        if (m_tvalid && m_tready) begin
            out_d.push_back(m_tdata);
            out_l.push_back(m_tlast);
        end
        @(negedge clk);
    endtask

    task automatic run_until(input int n, input int bound);
        for (int c = 0; c < bound && out_d.size() < n; c++) tick();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ena        = 1'b1;
        fifo_empty = 1'b1;
        m_tready   = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        src_q.delete();
        out_d.delete();
        out_l.delete();
        n_acc = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; fifo_empty = 1'b1; m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 8'h5a;
        @(negedge clk);
        #1;
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
        n_vec++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast got %b want 0", m_tlast); end
        n_vec++; if (m_tdata !== 8'h00) begin n_err++; $display("FAIL rst_tdata got %h want 00", m_tdata); end
        n_vec++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready got %b want 0", s_tready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (flushing !== 1'b0) begin n_err++; $display("FAIL rst_flushing got %b want 0", flushing); end
        do_reset();
        for (int c = 0; c < 3; c++) tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL idle_tvalid got %b want 0", m_tvalid); end
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < 4; i++) src_q.push_back(8'h10 + 8'(i));
        m_tready = 1'b1; fifo_empty = 1'b0;
        tick();
        fifo_empty = 1'b1;
        for (int c = 0; c < 20 && n_acc < 4; c++) tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy_fall got %b want 0", busy); end
        run_until(4, 20);
        n_vec++;
        if (out_d.size() != 4) begin n_err++; $display("FAIL burst_count got %0d want 4", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 4; i++) begin
            n_vec++;
            if (out_d[i] !== 8'h10 + 8'(i) || out_l[i] !== (i == 3)) begin
                n_err++;
                $display("FAIL burst_beat%0d got %h/%b want %h/%b", i, out_d[i], out_l[i],
                         8'h10 + 8'(i), (i == 3));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) src_q.push_back(8'h10 + 8'(i));
        m_tready = 1'b1; fifo_empty = 1'b0;
        tick();
        fifo_empty = 1'b1;
        for (int c = 0; c < 40 && out_d.size() < 4; c++) begin
            m_tready = ((c % 2) == 0);
            // Whatever is presented must be the next beat still owed.
            if (m_tvalid) begin
                n_vec++;
                if (m_tdata !== 8'h10 + 8'(out_d.size()) || m_tlast !== (out_d.size() == 3)) begin
                    n_err++;
                    $display("FAIL bp_present got %h/%b want %h/%b", m_tdata, m_tlast,
                             8'h10 + 8'(out_d.size()), (out_d.size() == 3));
                end
            end
            tick();
        end
        n_vec++;
        if (out_d.size() != 4) begin n_err++; $display("FAIL bp_count got %0d want 4", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 4; i++) begin
            n_vec++;
            if (out_d[i] !== 8'h10 + 8'(i) || out_l[i] !== (i == 3)) begin
                n_err++;
                $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, out_d[i], out_l[i],
                         8'h10 + 8'(i), (i == 3));
            end
        end
    endtask

    task automatic test_timeout_flush();
        do_reset();
        src_q.push_back(8'hA0); src_q.push_back(8'hA1);
        m_tready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        n_vec++; if (n_acc != 0) begin n_err++; $display("FAIL to_early_accept got %0d want 0", n_acc); end
        n_vec++; if (flushing !== 1'b1) begin n_err++; $display("FAIL to_flushing got %b want 1", flushing); end
        run_until(2, 20);
        n_vec++;
        if (out_d.size() != 2) begin n_err++; $display("FAIL to_count got %0d want 2", out_d.size()); end
        if (out_d.size() == 2) begin
            n_vec++;
            if (out_d[0] !== 8'hA0 || out_l[0] !== 1'b0) begin
                n_err++; $display("FAIL to_beat0 got %h/%b want a0/0", out_d[0], out_l[0]);
            end
            n_vec++;
            if (out_d[1] !== 8'hA1 || out_l[1] !== 1'b1) begin
                n_err++; $display("FAIL to_beat1 got %h/%b want a1/1", out_d[1], out_l[1]);
            end
        end
        for (int c = 0; c < 3; c++) tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_busy_end got %b want 0", busy); end
        n_vec++; if (flushing !== 1'b0) begin n_err++; $display("FAIL to_flush_end got %b want 0", flushing); end
    endtask

    task automatic test_long_flush();
        do_reset();
        for (int i = 0; i < 6; i++) src_q.push_back(8'h30 + 8'(i));
        m_tready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        n_vec++; if (n_acc != 0) begin n_err++; $display("FAIL lf_early_accept got %0d want 0", n_acc); end
        run_until(4, 20);
        for (int c = 0; c < 5; c++) tick();
        n_vec++; if (n_acc != 4) begin n_err++; $display("FAIL lf_held_back got %0d want 4", n_acc); end
        n_vec++; if (src_q.size() != 2) begin n_err++; $display("FAIL lf_residue got %0d want 2", src_q.size()); end
        run_until(6, 40);
        n_vec++;
        if (out_d.size() != 6) begin n_err++; $display("FAIL lf_count got %0d want 6", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 6; i++) begin
            n_vec++;
            if (out_d[i] !== 8'h30 + 8'(i) || out_l[i] !== (i == 3 || i == 5)) begin
                n_err++;
                $display("FAIL lf_beat%0d got %h/%b want %h/%b", i, out_d[i], out_l[i],
                         8'h30 + 8'(i), (i == 3 || i == 5));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 4; i++) src_q.push_back(8'h50 + 8'(i));
        m_tready = 1'b1; fifo_empty = 1'b0;
        tick();
        fifo_empty = 1'b1;
        for (int c = 0; c < 20 && n_acc < 2; c++) tick();
        n_vec++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid got %b want 1", m_tvalid); end
        rst = 1'b1;
        #1;
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rm_tvalid got %b want 0", m_tvalid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got %b want 0", busy); end
        n_vec++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rm_tready got %b want 0", s_tready); end
        @(negedge clk);
        rst = 1'b0;
        src_q.delete(); out_d.delete(); out_l.delete(); n_acc = 0;
        for (int i = 0; i < 4; i++) src_q.push_back(8'h60 + 8'(i));
        fifo_empty = 1'b0;
        tick();
        fifo_empty = 1'b1;
        run_until(4, 30);
        for (int c = 0; c < 4; c++) tick();
        n_vec++;
        if (out_d.size() != 4) begin n_err++; $display("FAIL rm_count got %0d want 4", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 4; i++) begin
            n_vec++;
            if (out_d[i] !== 8'h60 + 8'(i) || out_l[i] !== (i == 3)) begin
                n_err++;
                $display("FAIL rm_beat%0d got %h/%b want %h/%b", i, out_d[i], out_l[i],
                         8'h60 + 8'(i), (i == 3));
            end
        end
    endtask

    task automatic test_ena_freeze();
        do_reset();
        for (int i = 0; i < 4; i++) src_q.push_back(8'h70 + 8'(i));
        m_tready = 1'b1; fifo_empty = 1'b0;
        tick();
        fifo_empty = 1'b1;
        for (int c = 0; c < 20 && n_acc < 2; c++) tick();
        ena = 1'b0; m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if (m_tvalid !== 1'b1 || m_tdata !== 8'h70 || m_tlast !== 1'b0 || busy !== 1'b1
                || s_tready !== 1'b0) begin
                n_err++;
                $display("FAIL ena_frozen c%0d got v%b d%h l%b b%b r%b want v1 d70 l0 b1 r0", c,
                         m_tvalid, m_tdata, m_tlast, busy, s_tready);
            end
        end
        n_vec++; if (n_acc != 2) begin n_err++; $display("FAIL ena_no_accept got %0d want 2", n_acc); end
        ena = 1'b1; m_tready = 1'b1;
        run_until(4, 30);
        for (int c = 0; c < 4; c++) tick();
        n_vec++;
        if (out_d.size() != 4) begin n_err++; $display("FAIL ena_count got %0d want 4", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 4; i++) begin
            n_vec++;
            if (out_d[i] !== 8'h70 + 8'(i) || out_l[i] !== (i == 3)) begin
                n_err++;
                $display("FAIL ena_beat%0d got %h/%b want %h/%b", i, out_d[i], out_l[i],
                         8'h70 + 8'(i), (i == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(8'h80 + 8'(i));
        m_tready = 1'b1; fifo_empty = 1'b0;
        run_until(8, 60);
        fifo_empty = 1'b1;
        n_vec++;
        if (out_d.size() != 8) begin n_err++; $display("FAIL b2b_count got %0d want 8", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 8; i++) begin
            n_vec++;
            if (out_d[i] !== 8'h80 + 8'(i) || out_l[i] !== ((i % 4) == 3)) begin
                n_err++;
                $display("FAIL b2b_beat%0d got %h/%b want %h/%b", i, out_d[i], out_l[i],
                         8'h80 + 8'(i), ((i % 4) == 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_timeout_flush();
        test_long_flush();
        test_reset_mid_frame();
        test_ena_freeze();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
